frame_sample_buffer: RTL and testbench



---
 rtl/frame_sample_buffer.sv | 159 +++++++++++++++
 tb/tb_frame_sample_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sample_buffer.sv
// Circular sample store that emits overlapping frames of FRAME_LEN samples every HOP samples.
// Define PREEMPH_EN to apply x[n] - (31/32)x[n-1] pre-emphasis on the write path.
module frame_sample_buffer #(
  parameter int unsigned DWIDTH    = 30,
  parameter int unsigned AWIDTH    = 9,
  parameter int unsigned FRAME_LEN = 400,
  parameter int unsigned HOP       = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  input  logic              frame_start,
  output logic              frame_avail,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              overflow
);

  localparam int unsigned WORDS = 2 ** AWIDTH;

  localparam logic [AWIDTH:0]   FillMax   = (AWIDTH + 1)'(WORDS);
  localparam logic [AWIDTH:0]   FillFrame = (AWIDTH + 1)'(FRAME_LEN);
  localparam logic [AWIDTH:0]   FillHop   = (AWIDTH + 1)'(HOP);
  localparam logic [AWIDTH-1:0] AddrHop   = AWIDTH'(HOP);
  localparam logic [AWIDTH-1:0] IdxLast   = AWIDTH'(FRAME_LEN - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] wp_q, wp_d;
  logic [AWIDTH-1:0] rb_q, rb_d;
  logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [AWIDTH-1:0] rd_addr;
  logic [AWIDTH:0]   fill_q, fill_d;
  logic              overflow_q;
  logic              out_valid_q, out_last_q;
  logic [DWIDTH-1:0] out_data_q;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_en, rd_en;

  logic [DWIDTH-1:0] mem [WORDS];

  assign in_ready    = (fill_q != FillMax);
  assign frame_avail = (state_q == StIdle) && (fill_q >= FillFrame);
  assign wr_en       = in_valid && in_ready;
  assign rd_en       = (state_q == StRead);
  assign rd_addr     = rb_q + rd_idx_q;

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

`ifdef PREEMPH_EN
  // Computed two bits wider so the difference never wraps before saturation.
  logic [DWIDTH-1:0]        prev_q;
  logic signed [DWIDTH+1:0] in_ext, prev_ext, emph;

  always_comb begin
    in_ext   = {{2{in_data[DWIDTH-1]}}, in_data};
    prev_ext = {{2{prev_q[DWIDTH-1]}}, prev_q};
    emph     = in_ext - (prev_ext - (prev_ext >>> 5));
    if ((emph[DWIDTH+1:DWIDTH-1] == 3'b000) || (emph[DWIDTH+1:DWIDTH-1] == 3'b111)) begin
      wr_data = emph[DWIDTH-1:0];
    end else if (emph[DWIDTH+1]) begin
      wr_data = {1'b1, {(DWIDTH - 1){1'b0}}};
    end else begin
      wr_data = {1'b0, {(DWIDTH - 1){1'b1}}};
    end
  end

  // Dropped samples must not disturb the filter history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (wr_en) begin
      prev_q <= in_data;
    end
  end
`else
  assign wr_data = in_data;
`endif

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    rb_d     = rb_q;
    wp_d     = wr_en ? (wp_q + 1'b1) : wp_q;
    case (state_q)
      StIdle: begin
        if (frame_start && frame_avail) begin
          state_d  = StRead;
          rd_idx_d = '0;
        end
      end
      StRead: begin
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == IdxLast) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        rb_d    = rb_q + AddrHop;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // The frame window only moves forward in DRAIN; a write that cycle still counts.
    fill_d = fill_q + {{AWIDTH{1'b0}}, wr_en} - ((state_q == StDrain) ? FillHop : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wp_q       <= '0;
      rb_q       <= '0;
      rd_idx_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rb_q     <= rb_d;
      rd_idx_q <= rd_idx_d;
      fill_q   <= fill_d;
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Sample store; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= wr_data;
    end
  end

  // Registered read port; out_data holds between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_en;
      out_last_q  <= rd_en && (rd_idx_q == IdxLast);
      if (rd_en) begin
        out_data_q <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_frame_sample_buffer.sv
// Self-checking bench for frame_sample_buffer against a queue-based frame model.
module tb_frame_sample_buffer;

  localparam int DW    = 30;
  localparam int AW    = 4;
  localparam int FL    = 8;
  localparam int HP    = 4;
  localparam int WORDS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          frame_start = 1'b0;
  logic          in_ready, frame_avail, out_valid, out_last, overflow;
  logic [DW-1:0] out_data;
  logic [DW+4:0] obs_vec;

  int checks = 0;
  int errors = 0;

  frame_sample_buffer #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .FRAME_LEN(FL),
    .HOP      (HP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .frame_start(frame_start),
    .frame_avail(frame_avail),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  assign obs_vec = {out_valid, out_last, out_data, frame_avail, in_ready, overflow};

  // Reference model: stored samples from frame base onward, plus frame progress.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_frame[FL];
  bit            m_busy, m_ovf, m_valid, m_last;
  int            m_cnt;
  logic [DW-1:0] m_data;
`ifdef PREEMPH_EN
  longint        m_prev;
`endif

  function automatic bit m_avail();
    return !m_busy && (mq.size() >= FL);
  endfunction

  function automatic bit m_ready();
    return mq.size() != WORDS;
  endfunction

  function automatic logic [DW+4:0] exp_vec();
    return {m_valid, m_last, m_data, m_avail(), m_ready(), m_ovf};
  endfunction

  function automatic logic [DW-1:0] store_of(input logic [DW-1:0] d);
`ifdef PREEMPH_EN
    longint x, r, hi, lo;
    x  = longint'($signed(d));
    r  = x - (m_prev - (m_prev >>> 5));
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return DW'(r);
`else
    return d;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_busy  = 0;
    m_cnt   = 0;
    m_ovf   = 0;
    m_valid = 0;
    m_last  = 0;
    m_data  = '0;
`ifdef PREEMPH_EN
    m_prev  = 0;
`endif
  endtask

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic fs);
    bit acc, drain, start;
    acc   = v && m_ready();
    start = fs && m_avail();
    drain = m_busy && (m_cnt == FL + 1);
    if (v && !acc) m_ovf = 1;
    if (start) begin
      for (int k = 0; k < FL; k++) m_frame[k] = mq[k];
      m_busy = 1;
      m_cnt  = 1;
    end else if (m_busy) begin
      if (drain) m_busy = 0;
      else m_cnt++;
    end
    if (acc) begin
      mq.push_back(store_of(d));
`ifdef PREEMPH_EN
      m_prev = longint'($signed(d));
`endif
    end
    if (drain) repeat (HP) void'(mq.pop_front());
    m_valid = m_busy && (m_cnt >= 2);
    m_last  = m_valid && (m_cnt == FL + 1);
    if (m_valid) m_data = m_frame[m_cnt-2];
  endtask

  // One clock: drive inputs, advance model at the edge, leave time at edge + 1.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic fs);
    in_valid    = v;
    in_data     = d;
    frame_start = fs;
    @(posedge clk);
    if (!rst_n) model_clear();
    else model_edge(v, d, fs);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_clear();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset.out_last got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset.out_data got %h want 0", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset.overflow got %b want 0", overflow); end
    checks++; if (frame_avail !== 1'b0) begin errors++; $display("FAIL reset.frame_avail got %b want 0", frame_avail); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset.in_ready got %b want 1", in_ready); end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
    checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL reset.release got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_fill_read();
    int lasts;
    for (int i = 1; i <= FL; i++) begin
      step(1'b1, DW'(i), 1'b0);
      checks++; if (frame_avail !== (i == FL)) begin errors++; $display("FAIL fill.frame_avail i=%0d got %b want %b", i, frame_avail, (i == FL)); end
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL fill.model i=%0d got %h want %h", i, obs_vec, exp_vec()); end
    end
    step(1'b0, '0, 1'b1);
    lasts = 0;
    for (int c = 2; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      if (out_last === 1'b1) lasts++;
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL read1.model cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
`ifndef PREEMPH_EN
      if (c <= FL + 1) begin
        checks++; if (out_data !== DW'(c - 1) || out_valid !== 1'b1) begin errors++; $display("FAIL read1.data cyc=%0d got %0d/%b want %0d/1", c, out_data, out_valid, c - 1); end
      end
`endif
    end
    checks++; if (lasts != 1) begin errors++; $display("FAIL read1.last_count got %0d want 1", lasts); end
    checks++; if (frame_avail !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL read1.after_drain got avail=%b ready=%b want 0/1", frame_avail, in_ready); end
  endtask

  task automatic test_overlap();
    for (int v = 9; v <= 12; v++) begin
      step(1'b1, DW'(v), 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL overlap.fill v=%0d got %h want %h", v, obs_vec, exp_vec()); end
    end
    step(1'b0, '0, 1'b1);
    for (int c = 2; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL overlap.model cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
`ifndef PREEMPH_EN
      if (c <= FL + 1) begin
        checks++; if (out_data !== DW'(c + 3) || out_last !== (c == FL + 1)) begin errors++; $display("FAIL overlap.data cyc=%0d got %0d/%b want %0d/%b", c, out_data, out_last, c + 3, (c == FL + 1)); end
      end
`endif
    end
  endtask

  task automatic test_overflow_wrap();
    do_reset();
    for (int i = 1; i <= WORDS + 1; i++) begin
      step(1'b1, DW'(i), 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL ovf.fill i=%0d got %h want %h", i, obs_vec, exp_vec()); end
      if (i == WORDS) begin
        checks++; if (in_ready !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf.full got ready=%b ovf=%b want 0/0", in_ready, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf.sticky got %b want 1", overflow); end
    for (int f = 0; f < 3; f++) begin
      step(1'b0, '0, 1'b1);
      for (int c = 2; c <= FL + 2; c++) begin
        step(1'b0, '0, 1'b0);
        checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL ovf.frame%0d cyc=%0d got %h want %h", f, c, obs_vec, exp_vec()); end
`ifndef PREEMPH_EN
        if (c == 2) begin
          checks++; if (out_data !== DW'(1 + 4 * f)) begin errors++; $display("FAIL ovf.first%0d got %0d want %0d", f, out_data, 1 + 4 * f); end
        end
`endif
      end
    end
    step(1'b0, '0, 1'b1);
    for (int c = 1; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (out_valid !== 1'b0 || frame_avail !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ovf.ignored cyc=%0d got v=%b a=%b r=%b want 0/0/1", c, out_valid, frame_avail, in_ready); end
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < FL; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    // Write through READ and in the DRAIN cycle itself, skipping the last READ cycle.
    for (int c = 2; c <= FL + 2; c++) begin
      step((c <= FL) || (c == FL + 2), DW'($urandom), 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL conc.model cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
    end
    checks++; if (overflow !== 1'b0 || frame_avail !== 1'b1) begin errors++; $display("FAIL conc.after got ovf=%b avail=%b want 0/1", overflow, frame_avail); end
    step(1'b0, '0, 1'b1);
    for (int c = 2; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL conc.read2 cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < FL; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid.pre got out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rstmid.out got v=%b l=%b d=%h want 0/0/0", out_valid, out_last, out_data); end
    checks++; if (frame_avail !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid.flags got a=%b r=%b want 0/1", frame_avail, in_ready); end
    model_clear();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= FL; i++) step(1'b1, DW'(i + 100), 1'b0);
    step(1'b0, '0, 1'b1);
    for (int c = 2; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL rstmid.read cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
`ifndef PREEMPH_EN
      if (c <= FL + 1) begin
        checks++; if (out_data !== DW'(c + 99)) begin errors++; $display("FAIL rstmid.data cyc=%0d got %0d want %0d", c, out_data, c + 99); end
      end
`endif
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 25);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL random n=%0d got %h want %h", n, obs_vec, exp_vec()); end
    end
  endtask

`ifdef PREEMPH_EN
  task automatic test_preemph();
    logic [DW-1:0] vin [FL];
    logic [DW-1:0] want [5];
    logic [DW-1:0] maxv, minv;
    maxv = {1'b0, {(DW - 1){1'b1}}};
    minv = {1'b1, {(DW - 1){1'b0}}};
    vin[0] = DW'(32); vin[1] = DW'(32); vin[2] = DW'(-64); vin[3] = maxv; vin[4] = minv;
    vin[5] = '0; vin[6] = '0; vin[7] = '0;
    want[0] = DW'(32); want[1] = DW'(1); want[2] = DW'(-95); want[3] = maxv; want[4] = minv;
    do_reset();
    for (int i = 0; i < FL; i++) step(1'b1, vin[i], 1'b0);
    step(1'b0, '0, 1'b1);
    for (int c = 2; c <= FL + 2; c++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL preemph.model cyc=%0d got %h want %h", c, obs_vec, exp_vec()); end
      if (c <= 6) begin
        checks++; if (out_data !== want[c-2]) begin errors++; $display("FAIL preemph.value k=%0d got %h want %h", c - 2, out_data, want[c-2]); end
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_read();
    test_overlap();
    test_overflow_wrap();
    test_concurrent();
    test_reset_mid();
`ifdef PREEMPH_EN
    test_preemph();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
